// File: rtl/led_scan_scheduler.sv
// led_scan_scheduler
// ------------------
// Sequences an LED matrix refresh using binary code modulation. For each
// row and each brightness plane it asks the column shifter for data, blanks
// the panel, latches the new column data while switching the row decoder,
// and then enables the columns for a period that doubles with every plane.
//
// Parameters
//   ROWS  number of scanned rows (power of two, 2..16)
//   BITS  brightness planes per row (1..8)
//
// Ports
//   clk          single rising-edge clock
//   rst          asynchronous active-high reset
//   enable       scanning permitted while high
//   base_time    display length of plane 0 in cycles (0 behaves as 1)
//   shift_req    level request to the column shifter
//   shift_done   one-cycle completion strobe from the column shifter
//   shift_row    row address the shifter should load
//   shift_plane  plane index the shifter should load
//   row_sel      row currently driven to the row decoder
//   latch        one-cycle column latch strobe
//   oe_n         active-low column output enable
//   frame_start  one-cycle pulse when row 0 plane 0 begins shifting
//   busy         high whenever the scheduler is not idle

module led_scan_scheduler #(
  parameter int ROWS = 8,
  parameter int BITS = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int PW = (BITS > 1) ? $clog2(BITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [7:0]    base_time,
  output logic          shift_req,
  input  logic          shift_done,
  output logic [RW-1:0] shift_row,
  output logic [PW-1:0] shift_plane,
  output logic [RW-1:0] row_sel,
  output logic          latch,
  output logic          oe_n,
  output logic          frame_start,
  output logic          busy
);

  // The longest display period is 255 << (BITS-1), which needs 8+BITS-1 bits.
  localparam int TW = 8 + BITS - 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [RW-1:0] row;
  logic [PW-1:0] plane;
  logic [RW-1:0] row_sel_q;
  logic [TW-1:0] timer;
  logic          frame_start_q;

  logic [RW-1:0] adv_row;
  logic [PW-1:0] adv_plane;
  logic [RW-1:0] pos_row;
  logic [PW-1:0] pos_plane;
  logic [7:0]    base_eff;
  logic [TW-1:0] disp_len;
  logic          disp_end;

  // Work out where the scan goes after the current plane: the next plane of
  // the same row, or plane 0 of the following row once the last plane is
  // done. The row counter wraps back to 0 after the bottom row.
  always_comb begin
    adv_plane = plane + PW'(1);
    adv_row   = row;
    if (plane == PW'(BITS - 1)) begin
      adv_plane = '0;
      adv_row   = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
    end
  end

  // The display period is the plane-0 time scaled by 2^plane. A base time of
  // zero is promoted to one so the columns are never enabled for zero cycles.
  // The timer is loaded with length-1 and the period ends when it reads zero.
  always_comb begin
    base_eff  = (base_time == 8'd0) ? 8'd1 : base_time;
    disp_len  = TW'(base_eff) << plane;
    disp_end  = (state == DISPLAY) && (timer == '0);
    pos_row   = disp_end ? adv_row : row;
    pos_plane = disp_end ? adv_plane : plane;
  end

  // Next-state and output decode. Once a row/plane has been started it always
  // runs through to the end of its display period; enable is only consulted
  // when choosing whether to start the next one. shift_done only matters while
  // the shift request is actually outstanding.
  always_comb begin
    next_state = state;
    shift_req  = 1'b0;
    latch      = 1'b0;
    oe_n       = 1'b1;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable) next_state = SHIFT;
      end
      SHIFT: begin
        shift_req = 1'b1;
        if (shift_done) next_state = BLANK;
      end
      BLANK: begin
        next_state = LATCH;
      end
      LATCH: begin
        latch      = 1'b1;
        next_state = DISPLAY;
      end
      DISPLAY: begin
        oe_n = 1'b0;
        if (timer == '0) next_state = enable ? SHIFT : IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register. Because every output is decoded from the state, the
  // asynchronous reset blanks the panel immediately without waiting for a
  // clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Scan position, row decoder address, display timer and frame marker.
  // The row decoder only changes as LATCH is entered, so the newly latched
  // columns and the new row appear together while the panel is still blanked.
  // frame_start is registered so it is high for exactly the first SHIFT cycle
  // of row 0 plane 0, whether that SHIFT follows a display or follows IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row           <= '0;
      plane         <= '0;
      row_sel_q     <= '0;
      timer         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= (next_state == SHIFT) && (state != SHIFT) &&
                       (pos_row == '0) && (pos_plane == '0);
      if (disp_end) begin
        row   <= adv_row;
        plane <= adv_plane;
      end
      if (state == BLANK) begin
        row_sel_q <= row;
      end
      if (state == LATCH) begin
        timer <= disp_len - TW'(1);
      end else if ((state == DISPLAY) && (timer != '0)) begin
        timer <= timer - TW'(1);
      end
    end
  end

  assign shift_row   = row;
  assign shift_plane = plane;
  assign row_sel     = row_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// tb_led_scan_scheduler
// ---------------------
// Self-checking bench for led_scan_scheduler at ROWS=8, BITS=4. A monitor
// turns the oe_n waveform into a list of display periods (row, plane, length)
// and records latch and frame_start events. Each test compares those records
// with a reference that walks the scan order with plain arithmetic: slot k of
// a frame is row k/BITS, plane k%BITS, shown for max(base,1)*2^plane cycles.

module tb_led_scan_scheduler;

  localparam int ROWS  = 8;
  localparam int BITS  = 4;
  localparam int SLOTS = ROWS * BITS;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] base_time;
  logic       shift_req;
  logic       shift_done;
  logic [2:0] shift_row;
  logic [1:0] shift_plane;
  logic [2:0] row_sel;
  logic       latch;
  logic       oe_n;
  logic       frame_start;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int row;
    int plane;
    int len;
  } disp_t;

  disp_t disp_q[$];
  int    latch_q[$];
  int    fs_q[$];
  int    viol = 0;
  bit    in_disp = 1'b0;
  disp_t cur;

  int ack_delay  = 2;
  bit ack_en     = 1'b1;
  int manual_req = 0;
  int manual_ack = 0;
  int rsp_cnt    = 0;

  led_scan_scheduler #(.ROWS(ROWS), .BITS(BITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .base_time   (base_time),
    .shift_req   (shift_req),
    .shift_done  (shift_done),
    .shift_row   (shift_row),
    .shift_plane (shift_plane),
    .row_sel     (row_sel),
    .latch       (latch),
    .oe_n        (oe_n),
    .frame_start (frame_start),
    .busy        (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Monitor: on every falling edge, collect display periods from oe_n runs,
  // the row address seen at every latch pulse, how many periods had completed
  // when each frame_start appeared, and any cycle where the outputs
  // contradict each other (columns on while shifting/latching, or activity
  // while not busy).
  initial begin
    forever begin
      @(negedge clk);
      if (!oe_n) begin
        if (in_disp) begin
          cur.len++;
        end else begin
          in_disp   = 1'b1;
          cur.row   = int'(row_sel);
          cur.plane = int'(shift_plane);
          cur.len   = 1;
        end
      end else if (in_disp) begin
        disp_q.push_back(cur);
        in_disp = 1'b0;
      end
      if (latch) latch_q.push_back(int'(row_sel));
      if (frame_start) fs_q.push_back(disp_q.size());
      if (!oe_n && (shift_req || latch)) viol++;
      if (!busy && (!oe_n || shift_req || latch)) viol++;
    end
  end

  // Column shifter model: acknowledges an outstanding shift_req after
  // ack_delay falling edges with a one-cycle strobe, and can also fire a
  // stray strobe on request to probe that it is ignored outside SHIFT.
  initial begin
    shift_done = 1'b0;
    forever begin
      @(negedge clk);
      if (shift_done) begin
        shift_done = 1'b0;
      end else if (manual_req != manual_ack) begin
        shift_done = 1'b1;
        manual_ack = manual_req;
      end else if (ack_en && shift_req) begin
        if (rsp_cnt >= ack_delay) begin
          shift_done = 1'b1;
          rsp_cnt    = 0;
        end else begin
          rsp_cnt++;
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  function automatic int exp_len(int bt, int plane);
    return ((bt == 0) ? 1 : bt) << plane;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_periods(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (disp_q.size() < target && n < budget) begin
      step();
      n++;
    end
    ok = (disp_q.size() >= target);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    base_time = 8'd0;
    repeat (2) step();
    checks++; if (oe_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_oe_n got %b want 1", oe_n); end
    checks++; if (shift_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_shift_req got %b want 0", shift_req); end
    checks++; if (latch !== 1'b0) begin errors++; $display("[TB] FAIL reset_latch got %b want 0", latch); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start got %b want 0", frame_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (row_sel !== 3'd0) begin errors++; $display("[TB] FAIL reset_row_sel got %0d want 0", row_sel); end
    checks++; if (shift_row !== 3'd0 || shift_plane !== 2'd0) begin errors++; $display("[TB] FAIL reset_position got %0d/%0d want 0/0", shift_row, shift_plane); end
    rst = 1'b0;
    repeat (5) step();
    checks++; if (busy !== 1'b0 || oe_n !== 1'b1) begin errors++; $display("[TB] FAIL idle_hold busy=%b oe_n=%b want 0/1", busy, oe_n); end
  endtask

  task automatic test_basic();
    int d0, f0;
    bit ok;
    do_reset();
    base_time = 8'd3;
    ack_delay = 2;
    ack_en    = 1'b1;
    d0 = disp_q.size();
    f0 = fs_q.size();
    enable = 1'b1;
    wait_periods(d0 + 5, 2000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_timeout got %0d periods want %0d", disp_q.size() - d0, 5); end
    if (ok) begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (disp_q[d0+k].row != k / BITS || disp_q[d0+k].plane != k % BITS || disp_q[d0+k].len != exp_len(3, k % BITS)) begin
          errors++;
          $display("[TB] FAIL basic_period%0d got r%0d p%0d len%0d want r%0d p%0d len%0d", k, disp_q[d0+k].row, disp_q[d0+k].plane, disp_q[d0+k].len, k / BITS, k % BITS, exp_len(3, k % BITS));
        end
      end
    end
    checks++; if (fs_q.size() - f0 != 1) begin errors++; $display("[TB] FAIL basic_frame_count got %0d want 1", fs_q.size() - f0); end
    checks++; if (fs_q.size() > f0 && fs_q[f0] != d0) begin errors++; $display("[TB] FAIL basic_frame_pos got %0d want %0d", fs_q[f0], d0); end
  endtask

  task automatic test_base_zero();
    int d0;
    bit ok;
    do_reset();
    base_time = 8'd0;
    ack_delay = int'($urandom_range(0, 3));
    d0 = disp_q.size();
    enable = 1'b1;
    wait_periods(d0 + 4, 1000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL zero_timeout got %0d periods want 4", disp_q.size() - d0); end
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (disp_q[d0+k].len != (1 << k) || disp_q[d0+k].plane != k) begin
          errors++;
          $display("[TB] FAIL zero_period%0d got p%0d len%0d want p%0d len%0d", k, disp_q[d0+k].plane, disp_q[d0+k].len, k, 1 << k);
        end
      end
    end
  endtask

  task automatic test_base_sample();
    int d0, n, old_bt, new_bt;
    bit ok;
    do_reset();
    old_bt = int'($urandom_range(2, 9));
    new_bt = int'($urandom_range(1, 9));
    base_time = 8'(old_bt);
    ack_delay = int'($urandom_range(0, 3));
    d0 = disp_q.size();
    enable = 1'b1;
    n = 0;
    while (oe_n !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    base_time = 8'(new_bt);
    wait_periods(d0 + 2, 1000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL sample_timeout got %0d periods want 2", disp_q.size() - d0); end
    if (ok) begin
      checks++; if (disp_q[d0].len != old_bt) begin errors++; $display("[TB] FAIL sample_current got len%0d want len%0d", disp_q[d0].len, old_bt); end
      checks++; if (disp_q[d0+1].len != exp_len(new_bt, 1)) begin errors++; $display("[TB] FAIL sample_next got len%0d want len%0d", disp_q[d0+1].len, exp_len(new_bt, 1)); end
    end
  endtask

  task automatic test_full_frame();
    int d0, f0, l0, v0, bt;
    bit ok;
    do_reset();
    bt = int'($urandom_range(0, 3));
    base_time = 8'(bt);
    ack_delay = int'($urandom_range(0, 4));
    d0 = disp_q.size();
    f0 = fs_q.size();
    l0 = latch_q.size();
    v0 = viol;
    enable = 1'b1;
    wait_periods(d0 + SLOTS + 1, 5000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL frame_timeout got %0d periods want %0d", disp_q.size() - d0, SLOTS + 1); end
    if (ok) begin
      for (int k = 0; k <= SLOTS; k++) begin
        int slot;
        slot = k % SLOTS;
        checks++;
        if (disp_q[d0+k].row != slot / BITS || disp_q[d0+k].plane != slot % BITS || disp_q[d0+k].len != exp_len(bt, slot % BITS)) begin
          errors++;
          $display("[TB] FAIL frame_period%0d got r%0d p%0d len%0d want r%0d p%0d len%0d", k, disp_q[d0+k].row, disp_q[d0+k].plane, disp_q[d0+k].len, slot / BITS, slot % BITS, exp_len(bt, slot % BITS));
        end
      end
      checks++; if (latch_q.size() - l0 != SLOTS + 1) begin errors++; $display("[TB] FAIL frame_latch_count got %0d want %0d", latch_q.size() - l0, SLOTS + 1); end
      if (latch_q.size() - l0 >= SLOTS) begin
        for (int k = 0; k < SLOTS; k++) begin
          checks++;
          if (latch_q[l0+k] != k / BITS) begin errors++; $display("[TB] FAIL frame_latch_row%0d got %0d want %0d", k, latch_q[l0+k], k / BITS); end
        end
      end
      checks++; if (fs_q.size() - f0 != 2) begin errors++; $display("[TB] FAIL frame_start_count got %0d want 2", fs_q.size() - f0); end
      if (fs_q.size() - f0 >= 2) begin
        checks++; if (fs_q[f0] != d0 || fs_q[f0+1] != d0 + SLOTS) begin errors++; $display("[TB] FAIL frame_start_pos got %0d,%0d want %0d,%0d", fs_q[f0] - d0, fs_q[f0+1] - d0, 0, SLOTS); end
      end
    end
    checks++; if (viol != v0) begin errors++; $display("[TB] FAIL frame_output_conflicts got %0d want 0", viol - v0); end
  endtask

  task automatic test_enable_drop();
    int d0, f1, n;
    bit ok;
    do_reset();
    base_time = 8'd2;
    ack_delay = 1;
    d0 = disp_q.size();
    enable = 1'b1;
    n = 0;
    while (!(oe_n === 1'b0 && row_sel === 3'd2 && shift_plane === 2'd1) && n < 3000) begin
      step();
      n++;
    end
    checks++; if (n >= 3000) begin errors++; $display("[TB] FAIL drop_reach_timeout got %0d cycles want under 3000", n); end
    enable = 1'b0;
    wait_periods(d0 + 10, 500, ok);
    repeat (3) step();
    checks++; if (busy !== 1'b0 || oe_n !== 1'b1 || shift_req !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle got busy=%b oe_n=%b req=%b want 0/1/0", busy, oe_n, shift_req); end
    checks++; if (!ok || disp_q[d0+9].row != 2 || disp_q[d0+9].plane != 1 || disp_q[d0+9].len != 4) begin errors++; $display("[TB] FAIL drop_completed got %0d periods want row2 plane1 len4 completed", disp_q.size() - d0); end
    f1 = fs_q.size();
    enable = 1'b1;
    step();
    checks++; if (shift_req !== 1'b1 || shift_row !== 3'd2 || shift_plane !== 2'd2) begin errors++; $display("[TB] FAIL resume_target got req=%b r%0d p%0d want 1 r2 p2", shift_req, shift_row, shift_plane); end
    enable = 1'b0;
    wait_periods(d0 + 11, 500, ok);
    repeat (3) step();
    checks++; if (!ok || disp_q[d0+10].row != 2 || disp_q[d0+10].plane != 2 || disp_q[d0+10].len != 8) begin errors++; $display("[TB] FAIL resume_period got %0d periods want row2 plane2 len8 completed", disp_q.size() - d0); end
    checks++; if (fs_q.size() != f1) begin errors++; $display("[TB] FAIL resume_frame_start got %0d pulses want 0", fs_q.size() - f1); end
    checks++; if (busy !== 1'b0 || shift_plane !== 2'd3) begin errors++; $display("[TB] FAIL resume_idle got busy=%b p%0d want 0 p3", busy, shift_plane); end
  endtask

  task automatic test_shift_done_ignored();
    int d0, bad, n;
    bit ok;
    do_reset();
    ack_en    = 1'b0;
    base_time = 8'd5;
    manual_req++;
    repeat (3) step();
    checks++; if (busy !== 1'b0 || shift_req !== 1'b0) begin errors++; $display("[TB] FAIL stray_idle got busy=%b req=%b want 0/0", busy, shift_req); end
    d0 = disp_q.size();
    enable = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (oe_n !== 1'b1 || shift_req !== 1'b1) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL stall_hold got %0d bad cycles want 0", bad); end
    ack_en = 1'b1;
    n = 0;
    while (oe_n !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    manual_req++;
    wait_periods(d0 + 2, 500, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stray_timeout got %0d periods want 2", disp_q.size() - d0); end
    if (ok) begin
      checks++; if (disp_q[d0].len != 5 || disp_q[d0].plane != 0) begin errors++; $display("[TB] FAIL stray_display got p%0d len%0d want p0 len5", disp_q[d0].plane, disp_q[d0].len); end
      checks++; if (disp_q[d0+1].len != 10 || disp_q[d0+1].plane != 1) begin errors++; $display("[TB] FAIL stray_next got p%0d len%0d want p1 len10", disp_q[d0+1].plane, disp_q[d0+1].len); end
    end
  endtask

  task automatic test_reset_mid();
    int d0, d1, f1, n;
    bit ok;
    do_reset();
    base_time = 8'd4;
    ack_delay = int'($urandom_range(0, 3));
    d0 = disp_q.size();
    enable = 1'b1;
    wait_periods(d0 + 5, 1000, ok);
    n = 0;
    while (oe_n !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    checks++; if (oe_n !== 1'b0) begin errors++; $display("[TB] FAIL midrst_reach got oe_n=%b want 0", oe_n); end
    #1 rst = 1'b1;
    #1;
    checks++; if (oe_n !== 1'b1 || busy !== 1'b0 || latch !== 1'b0) begin errors++; $display("[TB] FAIL midrst_display_async got oe_n=%b busy=%b latch=%b want 1/0/0", oe_n, busy, latch); end
    checks++; if (row_sel !== 3'd0 || shift_row !== 3'd0 || shift_plane !== 2'd0) begin errors++; $display("[TB] FAIL midrst_position got r%0d sr%0d p%0d want 0/0/0", row_sel, shift_row, shift_plane); end
    repeat (2) step();
    d1 = disp_q.size();
    f1 = fs_q.size();
    rst = 1'b0;
    wait_periods(d1 + 2, 1000, ok);
    checks++; if (!ok || disp_q[d1].row != 0 || disp_q[d1].plane != 0 || disp_q[d1].len != 4 || disp_q[d1+1].plane != 1 || disp_q[d1+1].len != 8) begin errors++; $display("[TB] FAIL midrst_restart got %0d periods want r0 p0 len4 then p1 len8", disp_q.size() - d1); end
    checks++; if (fs_q.size() - f1 != 1 || (fs_q.size() > f1 && fs_q[f1] != d1)) begin errors++; $display("[TB] FAIL midrst_frame_start got %0d pulses want 1 at restart", fs_q.size() - f1); end
    ack_en = 1'b0;
    n = 0;
    while (shift_req !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (shift_req !== 1'b0 || oe_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_shift_async got req=%b oe_n=%b busy=%b want 0/1/0", shift_req, oe_n, busy); end
    ack_en = 1'b1;
    repeat (2) step();
    d1 = disp_q.size();
    rst = 1'b0;
    wait_periods(d1 + 1, 500, ok);
    checks++; if (!ok || disp_q[d1].row != 0 || disp_q[d1].plane != 0 || disp_q[d1].len != 4) begin errors++; $display("[TB] FAIL midrst_shift_restart got %0d periods want r0 p0 len4", disp_q.size() - d1); end
  endtask

  // Test sequence.
  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    base_time = 8'd0;
    test_reset();
    test_basic();
    test_base_zero();
    test_base_sample();
    test_full_frame();
    test_enable_drop();
    test_shift_done_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_scan_scheduler.md
LED_SCAN_SCHEDULER -- requirements
Module: led_scan_scheduler

Interface
REQ-001 SHALL provide parameter ROWS, default 8: number of matrix rows scanned, power of two, 2..16.
REQ-002 SHALL provide parameter BITS, default 4: brightness bit planes per row (binary code modulation), 1..8.
REQ-003 SHALL provide port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL provide port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL provide port enable, input, 1: scanning permitted while high.
REQ-006 SHALL provide port base_time, input, 8: display cycles for plane 0; value 0 treated as 1.
REQ-007 SHALL provide port shift_req, output, 1: level request to the column shifter to load data for shift_row/shift_plane.
REQ-008 SHALL provide port shift_done, input, 1: single-cycle shifter completion strobe.
REQ-009 SHALL provide port shift_row, output, log2(ROWS): row address for the pending shift.
REQ-010 SHALL provide port shift_plane, output, log2(BITS) (min 1): plane index for the pending shift.
REQ-011 SHALL provide port row_sel, output, log2(ROWS): row driven to the row decoder.
REQ-012 SHALL provide port latch, output, 1: one-cycle column latch strobe.
REQ-013 SHALL provide port oe_n, output, 1: column output enable, active-low.
REQ-014 SHALL provide port frame_start, output, 1: one-cycle pulse at start of each frame.
REQ-015 SHALL provide port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, SHIFT, BLANK, LATCH, DISPLAY.
REQ-017 IDLE: oe_n=1, shift_req=0; when enable=1, next state SHIFT.
REQ-018 SHIFT: shift_req=1, oe_n=1; held until shift_done sampled high, then next state BLANK with shift_req=0 the following cycle.
REQ-019 BLANK: exactly 1 cycle, oe_n=1, shift_req=0; next state LATCH.
REQ-020 LATCH: exactly 1 cycle, latch=1, oe_n=1; row_sel takes the value of shift_row on entry to LATCH; next state DISPLAY.
REQ-021 DISPLAY: oe_n=0 for exactly max(base_time,1) << shift_plane cycles; timer width 8+BITS-1 bits, no overflow.
REQ-022 base_time SHALL be sampled on entry to DISPLAY; changes during DISPLAY do not affect the current period.
REQ-023 At DISPLAY end: plane increments; if plane was BITS-1, plane wraps to 0 and row increments; row ROWS-1 wraps to 0.
REQ-024 After DISPLAY: next state SHIFT if enable=1, else IDLE; enable low in SHIFT/BLANK/LATCH/DISPLAY SHALL NOT abort the current row/plane.
REQ-025 frame_start SHALL pulse for 1 cycle on entry to SHIFT with row=0 and plane=0.
REQ-026 Re-entry from IDLE SHALL resume at the next unscanned row/plane, not restart the frame.
REQ-027 shift_done outside SHIFT SHALL be ignored; shift_done coincident with SHIFT entry is not possible (shift_req not yet visible).
REQ-028 latch SHALL be 0 in every state except LATCH; oe_n SHALL be 0 only in DISPLAY.
REQ-029 No stall limit in SHIFT; the scheduler waits indefinitely for shift_done with oe_n=1.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, row=0, plane=0, row_sel=0, oe_n=1, shift_req=0, latch=0, frame_start=0, busy=0, timer=0.
REQ-031 rst asserted mid-DISPLAY or mid-SHIFT SHALL blank outputs (oe_n=1) asynchronously; after release the first SHIFT is row 0 plane 0 with frame_start.

Verification
REQ-032 rst, then enable=1, base_time=3, shifter acks 2 cycles after shift_req -> frame_start once, then DISPLAY lengths 3,6,12,24 for row 0 planes 0..3, then row 1.
REQ-033 base_time=0 -> each DISPLAY lasts 1,2,4,8 cycles; no zero-length oe_n period.
REQ-034 full frame at ROWS=8, BITS=4 -> 32 latch pulses, row_sel sequence 0..7 each repeated 4 times, frame_start again after row 7 plane 3.
REQ-035 enable dropped mid-DISPLAY of row 2 plane 1 -> period completes, IDLE with oe_n=1; enable raised -> SHIFT for row 2 plane 2, no frame_start.
REQ-036 shift_done pulsed in IDLE and DISPLAY -> no state change; shift_done withheld 100 cycles in SHIFT -> oe_n stays 1, shift_req stays 1.
REQ-037 rst pulsed during DISPLAY -> oe_n=1 same cycle without clock edge; restart at row 0 plane 0.
